// File: rtl/ydemux2_stream.sv
// rtl/ydemux2_stream.sv - two-way stream demultiplexer with per-channel FIFOs; optional DEMUX_CHECK_EN adds proto_err
module ydemux2_stream #(
    parameter int SIZE  = 2,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_sel,
    output logic            out0_valid,
    input  logic            out0_ready,
    output logic [SIZE-1:0] out0_data,
    output logic            out1_valid,
    input  logic            out1_ready,
    output logic [SIZE-1:0] out1_data,
    output logic [CW-1:0]   cnt0,
`ifdef DEMUX_CHECK_EN
    output logic [CW-1:0]   cnt1,
    output logic            proto_err
`else
    output logic [CW-1:0]   cnt1
`endif
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCCW = AW + 1;

    logic [SIZE-1:0] mem0 [DEPTH];
    logic [SIZE-1:0] mem1 [DEPTH];
    logic [AW-1:0]   wr0, rd0, wr1, rd1;
    logic [OCCW-1:0] occ0, occ1;
    logic            full0, full1, empty0, empty1;
    logic            push0, push1, pop0, pop1;

    // Occupancy-derived status and handshakes; in_ready never looks at in_valid or the consumers
    always_comb begin
        full0    = (occ0 == OCCW'(DEPTH));
        full1    = (occ1 == OCCW'(DEPTH));
        empty0   = (occ0 == '0);
        empty1   = (occ1 == '0);
        in_ready = in_sel ? ~full1 : ~full0;
        push0    = in_valid & ~in_sel & ~full0;
        push1    = in_valid &  in_sel & ~full1;
        pop0     = ~empty0 & out0_ready;
        pop1     = ~empty1 & out1_ready;
    end

    // Head words are forced to zero while a channel is empty so stale storage never leaks out
    always_comb begin
        out0_valid = ~empty0;
        out1_valid = ~empty1;
        out0_data  = empty0 ? '0 : mem0[rd0];
        out1_data  = empty1 ? '0 : mem1[rd1];
    end

    // Channel 0 storage write; the array holds no control state so it is left out of reset
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr0] <= in_data;
        end
    end

    // Channel 1 storage write
    always_ff @(posedge clk) begin
        if (push1) begin
            mem1[wr1] <= in_data;
        end
    end

    // Channel 0 pointers, occupancy and accepted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr0  <= '0;
            rd0  <= '0;
            occ0 <= '0;
            cnt0 <= '0;
        end else begin
            if (push0) begin
                wr0  <= wr0 + AW'(1);
                cnt0 <= cnt0 + CW'(1);
            end
            if (pop0) begin
                rd0 <= rd0 + AW'(1);
            end
            occ0 <= occ0 + OCCW'(push0) - OCCW'(pop0);
        end
    end

    // Channel 1 pointers, occupancy and accepted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr1  <= '0;
            rd1  <= '0;
            occ1 <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) begin
                wr1  <= wr1 + AW'(1);
                cnt1 <= cnt1 + CW'(1);
            end
            if (pop1) begin
                rd1 <= rd1 + AW'(1);
            end
            occ1 <= occ1 + OCCW'(push1) - OCCW'(pop1);
        end
    end

`ifdef DEMUX_CHECK_EN
    logic            stall_q;
    logic [SIZE-1:0] data_q;
    logic            sel_q;
    logic            violation;

    // A stalled word must be re-presented unchanged on the very next edge
    always_comb begin
        violation = stall_q & (~in_valid | (in_data != data_q) | (in_sel != sel_q));
    end

    // Capture the stalled word and latch any violation until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= 1'b0;
            data_q    <= '0;
            sel_q     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            stall_q <= in_valid & ~in_ready;
            data_q  <= in_data;
            sel_q   <= in_sel;
            if (violation) begin
                proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ydemux2_stream.sv
// tb/tb_ydemux2_stream.sv - directed self-checking bench for ydemux2_stream
module tb_ydemux2_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_sel;
    logic       out0_valid, out0_ready;
    logic [1:0] out0_data;
    logic       out1_valid, out1_ready;
    logic [1:0] out1_data;
    logic [7:0] cnt0, cnt1;
`ifdef DEMUX_CHECK_EN
    logic       proto_err;
`endif

    int checks;
    int failures;

    ydemux2_stream #(.SIZE(2), .DEPTH(2), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
`ifdef DEMUX_CHECK_EN
        .cnt1       (cnt1),
        .proto_err  (proto_err)
`else
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 2'd0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset then idle
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        drive(0, 0, 0);
        check("rst_rdy_s0", in_ready, 1);
        drive(0, 1, 0);
        check("rst_rdy_s1", in_ready, 1);

        // Routing sweep
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 2; s++) begin
                drive(1, s[0], d[1:0]);
                check("sweep_rdy", in_ready, 1);
                tick();
                drive(0, 0, 0);
                if (s == 0) begin
                    check("sweep_v0", out0_valid, 1);
                    check("sweep_d0", out0_data, d);
                    check("sweep_other_v1", out1_valid, 0);
                end else begin
                    check("sweep_v1", out1_valid, 1);
                    check("sweep_d1", out1_data, d);
                    check("sweep_other_v0", out0_valid, 0);
                end
            end
        end
        check("sweep_cnt0", cnt0, 4);
        check("sweep_cnt1", cnt1, 4);
        tick();
        check("sweep_drain_v0", out0_valid, 0);
        check("sweep_drain_v1", out1_valid, 0);

        // Fill channel 0, channel 1 unaffected
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1, 0, 2'b01);
        tick();
        drive(1, 0, 2'b10);
        tick();
        drive(1, 0, 2'b11);
        check("fill_stall_rdy", in_ready, 0);
        drive(1, 1, 2'b11);
        check("fill_ch1_rdy", in_ready, 1);
        tick();
        check("fill_ch1_d", out1_data, 3);
        check("fill_ch0_head", out0_data, 1);
        drive(1, 0, 2'b11);
        out0_ready = 1'b1;
        #1;
        check("fill_full_rdy", in_ready, 0);
        tick();
        check("fill_pop1", out0_data, 2);
        check("fill_rdy_back", in_ready, 1);
        tick();
        drive(0, 0, 0);
        check("fill_pop2", out0_data, 3);
        check("fill_cnt0", cnt0, 7);
        check("fill_cnt1", cnt1, 5);
        tick();
        check("fill_empty_v0", out0_valid, 0);
        check("fill_hold_v1", out1_valid, 1);

        // Simultaneous push/pop with channel 1 full
        drive(1, 1, 2'b10);
        tick();
        drive(1, 1, 2'b01);
        out1_ready = 1'b1;
        #1;
        check("pp_full_rdy", in_ready, 0);
        tick();
        check("pp_rdy_next", in_ready, 1);
        check("pp_head", out1_data, 2);
        check("pp_cnt1_hold", cnt1, 6);
        out1_ready = 1'b0;
        tick();
        drive(0, 1, 0);
        check("pp_full_again", in_ready, 0);
        check("pp_head2", out1_data, 2);
        check("pp_cnt1", cnt1, 7);
        out1_ready = 1'b1;
        tick();
        check("pp_last", out1_data, 1);
        tick();
        check("pp_drained", out1_valid, 0);
        out1_ready = 1'b0;

        // Reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 0, 2'b01);
        tick();
        out0_ready = 1'b1;
        drive(1, 0, 2'b10);
        tick();
        drive(1, 0, 2'b11);
        tick();
        out0_ready = 1'b0;
        drive(1, 1, 2'b10);
        tick();
        check("mid_cnt0", cnt0, 3);
        check("mid_v0", out0_valid, 1);
        check("mid_d0", out0_data, 3);
        check("mid_v1", out1_valid, 1);
        rst = 1'b1;
        drive(1, 0, 2'b01);
        tick();
        rst = 1'b0;
        drive(0, 1'bx, 2'bxx);
        check("mid_rst_v0", out0_valid, 0);
        check("mid_rst_v1", out1_valid, 0);
        check("mid_rst_cnt0", cnt0, 0);
        check("mid_rst_cnt1", cnt1, 0);
        tick();
        check("mid_x_v0", out0_valid, 0);
        check("mid_x_v1", out1_valid, 0);
        check("mid_x_cnt0", cnt0, 0);
        check("mid_x_cnt1", cnt1, 0);

`ifdef DEMUX_CHECK_EN
        // Changing a stalled word sets the sticky error
        drive(0, 0, 0);
        check("pe_clear", proto_err, 0);
        drive(1, 0, 2'b00);
        tick();
        tick();
        drive(1, 0, 2'b10);
        check("pe_stall_rdy", in_ready, 0);
        tick();
        check("pe_after_stall", proto_err, 0);
        drive(1, 0, 2'b01);
        tick();
        check("pe_set", proto_err, 1);
        drive(0, 0, 0);
        tick();
        check("pe_sticky", proto_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("pe_rst", proto_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ydemux2_stream.md
Name: ydemux2_stream

Overview:
- Stream demultiplexer: inverse of the team's yMux2 word selector. One SIZE-bit input stream carries a per-word select bit, and each word is steered to one of two output channels.
- Each output channel has its own DEPTH-entry FIFO with valid/ready on both sides.
- Sits downstream of the lab mux datapath and is used to split time-multiplexed words back into per-channel streams.

Parameters:
- SIZE, 2, data word width in bits (1..32).
- DEPTH, 2, entries per channel FIFO; must be 2, 4 or 8.
- CW, 8, width of the per-channel accepted-word counters.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word can be accepted this cycle.
- in_data  input  SIZE  input word.
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1 (same polarity as yMux2 c).
- out0_valid  output  1  channel 0 head word valid.
- out0_ready  input  1  channel 0 consumer ready.
- out0_data  output  SIZE  channel 0 head word.
- out1_valid  output  1  channel 1 head word valid.
- out1_ready  input  1  channel 1 consumer ready.
- out1_data  output  SIZE  channel 1 head word.
- cnt0  output  CW  words accepted into channel 0, wraps modulo 2^CW.
- cnt1  output  CW  words accepted into channel 1, wraps modulo 2^CW.
- proto_err  output  1  present only with DEMUX_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clk edge): both FIFOs empty, pointers 0, cnt0=cnt1=0, out*_valid=0, out*_data=0, proto_err=0. Reset overrides any concurrent push or pop; words in flight are discarded.
- in_ready = ~full[in_sel]. It is combinational from in_sel and FIFO state only, never from in_valid or out*_ready.
- Push: in_valid & in_ready at an edge writes in_data at the tail of FIFO[in_sel] and increments cnt[in_sel].
- Pop: outN_valid & outN_ready at an edge removes the FIFO N head.
- outN_valid = ~empty[N]. outN_data = FIFO N head; it holds 0 when empty and is stable while valid & ~ready.
- Latency: a word pushed at edge t is visible on outN at t+1. There is no same-cycle bypass.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee between channels.
- Full boundary: when FIFO N is full and in_sel=N, in_ready=0 even if outN_ready=1 in the same cycle (no pass-through on full). The pop still occurs, and in_ready rises the next cycle.
- Empty boundary: push and pop on the same channel in the same cycle while the FIFO is non-empty leaves occupancy unchanged. When empty, only the push happens.
- Channels are independent: a full channel 1 never stalls words with in_sel=0.
- Pointers are log2(DEPTH)-bit, wrapping modulo DEPTH. Full/empty come from a (log2(DEPTH)+1)-bit occupancy count per channel.
- Counter wrap: cnt at 2^CW-1 wraps to 0 on the next push.
- in_data and in_sel are ignored when in_valid=0. X on in_sel while in_valid=0 must not corrupt state.

Optional Feature:
- Macro: DEMUX_CHECK_EN.
- With the macro: adds output proto_err, a sticky flag set the cycle after any stall violation. A violation is: in_valid=1 & in_ready=0 at edge t, then at edge t+1 either in_valid=0, or in_data/in_sel differs from edge t. proto_err clears only on rst. Datapath behaviour is unchanged.
- Without the macro: the proto_err port and its capture registers do not exist.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> all outputs 0, in_ready=1 for both in_sel values, cnt0=cnt1=0.
- Routing sweep: for every in_data 0..3 and in_sel 0..1, push one word with out*_ready=1 -> word appears on the matching channel next cycle with identical data; the other channel's valid stays 0. Final cnt0=4, cnt1=4.
- Fill channel 0: out0_ready=0, push 2'b01, 2'b10, then 2'b11 with in_sel=0 -> third word stalls with in_ready=0. in_sel=1 with 2'b11 is accepted the same cycle. Release out0_ready -> 01 then 10 pop in order, then 11 is accepted.
- Simultaneous push/pop at full: channel 1 full, out1_ready=1, in_valid=1, in_sel=1 -> no accept that cycle; accepted the next cycle; occupancy ends at DEPTH.
- Reset mid-operation: both FIFOs holding 1 word, cnt0=3, rst=1 with in_valid=1 -> next cycle both valids are 0, counts are 0, and the pushed word is absent.
- DEMUX_CHECK_EN: stall in_sel=0 with data 2'b10, then change data to 2'b01 while stalled -> proto_err=1 the next cycle and it stays 1 until rst.
